// File: rtl/serial_digit_adder_sub_if.sv
// Handshake bundle for the digit-serial adder/subtractor: input digit stream,
// output digit stream and word-end flags.
interface serial_digit_adder_sub_if #(
  parameter int unsigned DIGIT_W = 4
);
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] a_digit;
  logic [DIGIT_W-1:0] b_digit;
  logic               sub;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] sum_digit;
  logic               out_last;
  logic               carry_out;
  logic               overflow;

  modport master (
    output clear, in_valid, a_digit, b_digit, sub, out_ready,
    input  in_ready, out_valid, sum_digit, out_last, carry_out, overflow
  );

  modport slave (
    input  clear, in_valid, a_digit, b_digit, sub, out_ready,
    output in_ready, out_valid, sum_digit, out_last, carry_out, overflow
  );
endinterface

// File: rtl/serial_digit_adder_sub.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit words stream LSB
// digit first, DIGIT_W bits per transfer, with word-end carry and overflow.
module serial_digit_adder_sub #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_digit_adder_sub_if.slave bus
);

  localparam int unsigned N     = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
      $error("serial_digit_adder_sub: DIGIT_W must divide WIDTH");
    end
  endgenerate

  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               mode_q;
  logic               out_valid_q;
  logic [DIGIT_W-1:0] sum_digit_q;
  logic               out_last_q;
  logic               carry_out_q;
  logic               overflow_q;

  logic               first;
  logic               last;
  logic               sub_eff;
  logic               xfer;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] sum_c;
  logic               carry_c;
  logic               carry_msb_in;

  assign bus.in_ready = ~bus.clear & (~out_valid_q | bus.out_ready);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign first        = (cnt_q == '0);
  assign last         = (cnt_q == CNT_W'(N - 1));
  assign sub_eff      = first ? bus.sub : mode_q;
  assign b_eff        = sub_eff ? ~bus.b_digit : bus.b_digit;

  // Ripple of full adders across one digit; digit 0 takes the mode as carry-in.
  always_comb begin
    logic c;
    sum_c        = '0;
    carry_msb_in = 1'b0;
    c            = first ? bus.sub : carry_q;
    for (int i = 0; i < int'(DIGIT_W); i++) begin
      sum_c[i] = bus.a_digit[i] ^ b_eff[i] ^ c;
      if (i == int'(DIGIT_W) - 1) carry_msb_in = c;
      c = (bus.a_digit[i] & b_eff[i]) | (c & (bus.a_digit[i] ^ b_eff[i]));
    end
    carry_c = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_digit_q <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (bus.clear) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (xfer) begin
      sum_digit_q <= sum_c;
      out_last_q  <= last;
      out_valid_q <= 1'b1;
      mode_q      <= sub_eff;
      if (last) begin
        cnt_q       <= '0;
        carry_q     <= 1'b0;
        carry_out_q <= carry_c;
        overflow_q  <= carry_c ^ carry_msb_in;
      end else begin
        cnt_q       <= cnt_q + CNT_W'(1);
        carry_q     <= carry_c;
        carry_out_q <= 1'b0;
        overflow_q  <= 1'b0;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_digit = sum_digit_q;
  assign bus.out_last  = out_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_serial_digit_adder_sub.sv
// Bench for serial_digit_adder_sub: directed 8-bit/4-bit-digit vectors and
// corner sequences, plus random 32-bit/1-bit-digit words against A+/-B.
module tb_serial_digit_adder_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_digit_adder_sub_if #(.DIGIT_W(4)) bus8 ();
  serial_digit_adder_sub_if #(.DIGIT_W(1)) bus32 ();

  serial_digit_adder_sub #(.WIDTH(8), .DIGIT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
  );
  serial_digit_adder_sub #(.WIDTH(32), .DIGIT_W(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .bus(bus32.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       tog;
    logic [7:0] sum;
    logic       c;
    logic       v;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stream one 8-bit word at full rate with out_ready=1; optionally flip sub on digit 1.
  task automatic word8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic tog,
                       output logic [7:0] sum, output logic c, output logic v);
    sum = '0;
    for (int d = 0; d < 2; d++) begin
      bus8.in_valid = 1'b1;
      bus8.a_digit  = a[d*4 +: 4];
      bus8.b_digit  = b[d*4 +: 4];
      bus8.sub      = (d == 1 && tog) ? ~s : s;
      @(posedge clk); #1;
      check({nm, " out_valid"}, 32'(bus8.out_valid), 32'd1);
      check({nm, " out_last"}, 32'(bus8.out_last), 32'(d == 1));
      if (d == 0) check({nm, " flags mid-word"}, 32'({bus8.carry_out, bus8.overflow}), 32'd0);
      sum[d*4 +: 4] = bus8.sum_digit;
    end
    c = bus8.carry_out;
    v = bus8.overflow;
    bus8.in_valid = 1'b0;
    bus8.sub      = 1'b0;
  endtask

  task automatic send_digit8(input logic [3:0] a, input logic [3:0] b, input logic s);
    bus8.in_valid = 1'b1;
    bus8.a_digit  = a;
    bus8.b_digit  = b;
    bus8.sub      = s;
  endtask

  initial begin
    logic [7:0]  sum;
    logic        c, v;
    logic [31:0] a32, b32, r32, sum32;
    logic [32:0] full;
    logic        s32, ov32;

    vecs[0] = '{"add 3C+4F",   8'h3C, 8'h4F, 1'b0, 1'b0, 8'h8B, 1'b0, 1'b1};
    vecs[1] = '{"sub 10-01",   8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0};
    vecs[2] = '{"add FF+01 tg",8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{"add 7F+01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{"sub 80-01",   8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{"sub 00-01",   8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{"sub 05-05",   8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{"add AB+CD",   8'hAB, 8'hCD, 1'b0, 1'b0, 8'h78, 1'b1, 1'b1};

    bus8.clear = 1'b0; bus8.in_valid = 1'b0; bus8.a_digit = '0; bus8.b_digit = '0;
    bus8.sub = 1'b0; bus8.out_ready = 1'b1;
    bus32.clear = 1'b0; bus32.in_valid = 1'b0; bus32.a_digit = '0; bus32.b_digit = '0;
    bus32.sub = 1'b0; bus32.out_ready = 1'b1;

    // Reset state
    #12;
    check("reset out_valid", 32'(bus8.out_valid), 32'd0);
    check("reset sum_digit", 32'(bus8.sum_digit), 32'd0);
    check("reset flags", 32'({bus8.out_last, bus8.carry_out, bus8.overflow}), 32'd0);
    check("reset in_ready", 32'(bus8.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven words
    foreach (vecs[i]) begin
      word8(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].tog, sum, c, v);
      check({vecs[i].name, " sum"}, 32'(sum), 32'(vecs[i].sum));
      check({vecs[i].name, " carry_out"}, 32'(c), 32'(vecs[i].c));
      check({vecs[i].name, " overflow"}, 32'(v), 32'(vecs[i].v));
    end
    @(posedge clk); #1;
    check("drain out_valid", 32'(bus8.out_valid), 32'd0);

    // Backpressure: hold out_ready low after the first digit
    send_digit8(4'hC, 4'hF, 1'b0);
    bus8.out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp first digit", 32'(bus8.sum_digit), 32'hB);
    send_digit8(4'h3, 4'h4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("bp in_ready low", 32'(bus8.in_ready), 32'd0);
      @(posedge clk); #1;
      check("bp hold valid", 32'(bus8.out_valid), 32'd1);
      check("bp hold digit", 32'({bus8.out_last, bus8.sum_digit}), 32'h0B);
    end
    bus8.out_ready = 1'b1;
    #1;
    check("bp in_ready resume", 32'(bus8.in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp last digit", 32'({bus8.out_valid, bus8.out_last, bus8.sum_digit}), 32'h38);
    check("bp flags", 32'({bus8.carry_out, bus8.overflow}), 32'd1);
    bus8.in_valid = 1'b0;
    @(posedge clk); #1;

    // Clear after digit 0 leaves no stale carry or digit count
    send_digit8(4'hC, 4'hF, 1'b0);
    @(posedge clk); #1;
    send_digit8(4'h3, 4'h4, 1'b1);
    bus8.clear = 1'b1;
    #1;
    check("clear in_ready", 32'(bus8.in_ready), 32'd0);
    @(posedge clk); #1;
    bus8.clear = 1'b0;
    bus8.in_valid = 1'b0;
    check("clear out_valid", 32'(bus8.out_valid), 32'd0);
    word8("after clear", 8'h01, 8'h01, 1'b0, 1'b0, sum, c, v);
    check("after clear sum", 32'({sum, c, v}), 32'h008);
    @(posedge clk); #1;

    // Reset pulse mid-word behaves like clear
    send_digit8(4'hC, 4'hF, 1'b0);
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("midword reset out_valid", 32'(bus8.out_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after reset idle", 32'(bus8.out_valid), 32'd0);
    word8("after reset", 8'h01, 8'h01, 1'b0, 1'b0, sum, c, v);
    check("after reset sum", 32'({sum, c, v}), 32'h008);
    @(posedge clk); #1;

    // Random 32-bit words, one bit per transfer, with mid-word sub noise
    for (int w = 0; w < 1000; w++) begin
      a32 = $urandom;
      b32 = $urandom;
      s32 = 1'($urandom_range(0, 1));
      if (s32) full = {1'b0, a32} + {1'b0, ~b32} + 33'd1;
      else     full = {1'b0, a32} + {1'b0, b32};
      r32  = full[31:0];
      ov32 = s32 ? ((a32[31] != b32[31]) && (r32[31] != a32[31]))
                 : ((a32[31] == b32[31]) && (r32[31] != a32[31]));
      sum32 = '0;
      for (int d = 0; d < 32; d++) begin
        bus32.in_valid = 1'b1;
        bus32.a_digit  = a32[d];
        bus32.b_digit  = b32[d];
        bus32.sub      = (d == 0) ? s32 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        sum32[d] = bus32.sum_digit[0];
        if (d == 31) begin
          check("w32 last", 32'({bus32.out_valid, bus32.out_last}), 32'd3);
          check("w32 sum", sum32, r32);
          check("w32 flags", 32'({bus32.carry_out, bus32.overflow}), 32'({full[32], ov32}));
        end
      end
      bus32.in_valid = 1'b0;
    end
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
